// File: rtl/alu_issue_ctrl_if.sv
// Issue-stage bundle: instruction handshake, ALU operand/result path,
// writeback report and external register-file preload port.
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
);
  localparam int INSTR_W = 4 + 3 * REG_AW;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;

  logic [DATA_W-1:0]  alu_input1;
  logic [DATA_W-1:0]  alu_input2;
  logic [3:0]         alu_operation;
  logic [DATA_W-1:0]  alu_result;

  logic               wb_valid;
  logic [REG_AW-1:0]  wb_addr;
  logic [DATA_W-1:0]  wb_data;

  logic               ext_we;
  logic [REG_AW-1:0]  ext_addr;
  logic [DATA_W-1:0]  ext_wdata;

  logic               busy;

  // Instruction source / ALU / preload side
  modport master (
    output instr_valid, instr, alu_result, ext_we, ext_addr, ext_wdata,
    input  instr_ready, alu_input1, alu_input2, alu_operation,
           wb_valid, wb_addr, wb_data, busy
  );

  // Issue controller side
  modport slave (
    input  instr_valid, instr, alu_result, ext_we, ext_addr, ext_wdata,
    output instr_ready, alu_input1, alu_input2, alu_operation,
           wb_valid, wb_addr, wb_data, busy
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for a combinational ALU with a local register file.
// Optional ILLEGAL_OP_TRAP_EN: opcodes 5..15 skip writeback and set sticky illegal_op.
//   state | meaning
//   IDLE  | ready for an instruction
//   EXEC  | operands/opcode on ALU, result captured at closing edge
//   WB    | writeback of captured result to R[rd]
module alu_issue_ctrl #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic             illegal_op,
`endif
  alu_issue_ctrl_if.slave  bus
);
  localparam int NREG = 1 << REG_AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0]        op_q;
  logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] rdata1, rdata2;
  logic              accept, wb_fire, op_legal;

`ifdef ILLEGAL_OP_TRAP_EN
  assign op_legal = (op_q <= 4'd4);
`else
  assign op_legal = 1'b1;
`endif

  // R0 never holds a nonzero value, but the explicit mux keeps reads obviously zero.
  assign rdata1 = (rs1_q == '0) ? '0 : regs[rs1_q];
  assign rdata2 = (rs2_q == '0) ? '0 : regs[rs2_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    accept            = 1'b0;
    wb_fire           = 1'b0;
    bus.instr_ready   = 1'b0;
    bus.busy          = 1'b0;
    bus.alu_input1    = '0;
    bus.alu_input2    = '0;
    bus.alu_operation = '0;
    bus.wb_valid      = 1'b0;
    bus.wb_addr       = '0;
    bus.wb_data       = '0;
    case (state)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        bus.busy          = 1'b1;
        bus.alu_input1    = rdata1;
        bus.alu_input2    = rdata2;
        bus.alu_operation = op_q;
        state_nxt         = WB;
      end
      WB: begin
        bus.busy     = 1'b1;
        wb_fire      = op_legal;
        bus.wb_valid = op_legal;
        bus.wb_addr  = rd_q;
        bus.wb_data  = result_q;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) {op_q, rd_q, rs1_q, rs2_q} <= bus.instr;
      if (state == EXEC) result_q <= bus.alu_result;
    end
  end

  // Writeback is assigned last so it wins over a same-edge preload to the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (bus.ext_we && bus.ext_addr != '0) regs[bus.ext_addr] <= bus.ext_wdata;
      if (wb_fire && rd_q != '0) regs[rd_q] <= result_q;
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         illegal_op <= 1'b0;
    else if (state == WB && !op_legal) illegal_op <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: models the ALU and a shadow register file,
// scoreboards writebacks against a queue of expected results.
module tb_alu_issue_ctrl;
  localparam int DATA_W = 32;
  localparam int REG_AW = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  typedef struct {
    bit          legal;
    logic [3:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_op;
`endif

  int checks   = 0;
  int failures = 0;

  exp_t        q[$];
  logic [31:0] shadow [16];

  alu_issue_ctrl_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  alu_issue_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef ILLEGAL_OP_TRAP_EN
    .illegal_op (illegal_op),
`endif
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit op_is_legal(input logic [3:0] op);
`ifdef ILLEGAL_OP_TRAP_EN
    return op <= 4'd4;
`else
    return op == op;
`endif
  endfunction

  assign bus.alu_result = ref_alu(bus.alu_operation, bus.alu_input1, bus.alu_input2);

  task automatic ext_write(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.ext_we = 1'b1; bus.ext_addr = addr; bus.ext_wdata = data;
    @(posedge clk); #1;
    bus.ext_we = 1'b0;
    if (addr != 0) shadow[addr] = data;
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                           input logic [3:0] rs2, input bit collide, output logic [31:0] got);
    exp_t e;
    logic [31:0] a, b;
    int seen;
    bit legal;
    a = shadow[rs1];
    b = shadow[rs2];
    legal   = op_is_legal(op);
    e.legal = legal; e.rd = rd; e.data = ref_alu(op, a, b);
    q.push_back(e);
    if (legal && rd != 0) shadow[rd] = e.data;
    got  = '0;
    seen = -1;
    @(negedge clk);
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      failures++; $display("FAIL issue_ready got=%b exp=1", bus.instr_ready);
    end
    bus.instr_valid = 1'b1;
    bus.instr = {op, rd, rs1, rs2};
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (bus.alu_operation !== op || bus.alu_input1 !== a || bus.alu_input2 !== b || bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL exec_drive got op=%h a=%h b=%h busy=%b exp op=%h a=%h b=%h busy=1",
                   bus.alu_operation, bus.alu_input1, bus.alu_input2, bus.busy, op, a, b);
        end
      end
      if (bus.wb_valid === 1'b1) begin
        if (seen < 0) seen = c;
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL unexpected_wb got addr=%h data=%h", bus.wb_addr, bus.wb_data);
        end else begin
          e = q.pop_front();
          got = bus.wb_data;
          if (bus.wb_addr !== e.rd || bus.wb_data !== e.data || !e.legal) begin
            failures++;
            $display("FAIL wb_result got addr=%h data=%h exp addr=%h data=%h legal=%0d",
                     bus.wb_addr, bus.wb_data, e.rd, e.data, e.legal);
          end
        end
        if (collide) begin
          bus.ext_we = 1'b1; bus.ext_addr = rd; bus.ext_wdata = 32'hDEAD_BEEF;
          @(posedge clk); #1;
          bus.ext_we = 1'b0;
        end
      end
    end
    checks++;
    if (legal && seen != 2) begin
      failures++; $display("FAIL wb_latency got=%0d exp=2", seen);
    end else if (!legal && seen != -1) begin
      failures++; $display("FAIL wb_suppressed got=%0d exp=-1", seen);
    end
    if (seen < 0 && q.size() > 0) void'(q.pop_front());
  endtask

  task automatic read_reg(input logic [3:0] r, input logic [31:0] exp, input string name);
    logic [31:0] got;
    run_instr(OP_OR, 4'd0, r, 4'd0, 1'b0, got);
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (bus.instr_ready !== 1'b1 || bus.busy !== 1'b0 || bus.wb_valid !== 1'b0 ||
        bus.wb_addr !== '0 || bus.wb_data !== '0 || bus.alu_input1 !== '0 ||
        bus.alu_input2 !== '0 || bus.alu_operation !== '0) begin
      failures++;
      $display("FAIL %s got rdy=%b busy=%b wbv=%b wba=%h wbd=%h a=%h b=%h op=%h exp rdy=1 rest=0",
               name, bus.instr_ready, bus.busy, bus.wb_valid, bus.wb_addr, bus.wb_data,
               bus.alu_input1, bus.alu_input2, bus.alu_operation);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    check_idle_outputs("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_released");
`ifdef ILLEGAL_OP_TRAP_EN
    checks++;
    if (illegal_op !== 1'b0) begin failures++; $display("FAIL reset_illegal_op got=%b exp=0", illegal_op); end
`endif
    read_reg(4'd5, 32'h0, "reset_reg5");
  endtask

  task automatic test_add;
    logic [31:0] got;
    ext_write(4'd1, 32'd5);
    ext_write(4'd2, 32'd3);
    run_instr(OP_ADD, 4'd3, 4'd1, 4'd2, 1'b0, got);
    checks++;
    if (got !== 32'd8) begin failures++; $display("FAIL add_wb got=%h exp=8", got); end
    read_reg(4'd3, 32'd8, "add_r3");
  endtask

  task automatic test_sub_wrap;
    logic [31:0] got;
    ext_write(4'd1, 32'd0);
    ext_write(4'd2, 32'd1);
    run_instr(OP_SUB, 4'd4, 4'd1, 4'd2, 1'b0, got);
    checks++;
    if (got !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sub_wb got=%h exp=ffffffff", got); end
    run_instr(OP_ADD, 4'd5, 4'd4, 4'd2, 1'b0, got);
    read_reg(4'd5, 32'h0, "add_wrap_r5");
  endtask

  task automatic test_logic;
    logic [31:0] got;
    ext_write(4'd1, 32'hF0F0_F0F0);
    ext_write(4'd2, 32'h0FF0_0FF0);
    run_instr(OP_AND, 4'd7, 4'd1, 4'd2, 1'b0, got);
    run_instr(OP_OR,  4'd8, 4'd1, 4'd2, 1'b0, got);
    run_instr(OP_XOR, 4'd9, 4'd1, 4'd2, 1'b0, got);
    read_reg(4'd7, 32'h00F0_00F0, "and_r7");
    read_reg(4'd8, 32'hFFF0_FFF0, "or_r8");
    read_reg(4'd9, 32'hFF00_FF00, "xor_r9");
  endtask

  task automatic test_back_to_back;
    logic [15:0] prog [3];
    exp_t e;
    int idx, last, pops;
    bit adv;
    prog[0] = {OP_ADD, 4'd10, 4'd1,  4'd2};
    prog[1] = {OP_SUB, 4'd11, 4'd10, 4'd1};
    prog[2] = {OP_XOR, 4'd12, 4'd11, 4'd2};
    idx = 0; last = -1; pops = 0; adv = 1'b0;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = prog[0];
    for (int cyc = 0; cyc < 30 && pops < 3; cyc++) begin
      checks++;
      if (bus.instr_ready !== !bus.busy) begin
        failures++; $display("FAIL b2b_ready got=%b busy=%b", bus.instr_ready, bus.busy);
      end
      if (bus.wb_valid === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        pops++;
        checks++;
        if (bus.wb_addr !== e.rd || bus.wb_data !== e.data) begin
          failures++;
          $display("FAIL b2b_wb got addr=%h data=%h exp addr=%h data=%h",
                   bus.wb_addr, bus.wb_data, e.rd, e.data);
        end
      end
      if (bus.instr_valid && bus.instr_ready) begin
        e.legal = 1'b1;
        e.rd    = prog[idx][11:8];
        e.data  = ref_alu(prog[idx][15:12], shadow[prog[idx][7:4]], shadow[prog[idx][3:0]]);
        q.push_back(e);
        shadow[e.rd] = e.data;
        if (last >= 0) begin
          checks++;
          if (cyc - last != 3) begin failures++; $display("FAIL b2b_spacing got=%0d exp=3", cyc - last); end
        end
        last = cyc;
        idx++;
        adv = 1'b1;
      end
      @(negedge clk);
      if (adv) begin
        adv = 1'b0;
        if (idx < 3) bus.instr = prog[idx];
        else bus.instr_valid = 1'b0;
      end
    end
    bus.instr_valid = 1'b0;
    checks++;
    if (pops != 3 || idx != 3) begin
      failures++; $display("FAIL b2b_count got pops=%0d accepts=%0d exp 3/3", pops, idx);
    end
    q.delete();
  endtask

  task automatic test_r0_and_collide;
    logic [31:0] got;
    run_instr(OP_ADD, 4'd0, 4'd1, 4'd2, 1'b0, got);
    read_reg(4'd0, 32'h0, "r0_after_wb");
    ext_write(4'd0, 32'd55);
    read_reg(4'd0, 32'h0, "r0_after_ext");
    run_instr(OP_ADD, 4'd6, 4'd1, 4'd2, 1'b1, got);
    read_reg(4'd6, 32'h00E1_00E0, "collide_r6");
  endtask

  task automatic test_reset_mid_exec;
    bit saw_wb;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = {OP_ADD, 4'd13, 4'd1, 4'd2};
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_outputs("reset_mid_exec");
    @(negedge clk);
    rst = 1'b0;
    saw_wb = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.wb_valid === 1'b1) saw_wb = 1'b1;
    end
    checks++;
    if (saw_wb) begin failures++; $display("FAIL reset_discard got wb_valid=1 exp=0"); end
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    q.delete();
    read_reg(4'd13, 32'h0, "reset_r13");
    read_reg(4'd1,  32'h0, "reset_r1");
  endtask

  task automatic test_illegal_op;
    logic [31:0] got;
    ext_write(4'd7, 32'd123);
    run_instr(4'b0111, 4'd7, 4'd1, 4'd2, 1'b0, got);
`ifdef ILLEGAL_OP_TRAP_EN
    checks++;
    if (illegal_op !== 1'b1) begin failures++; $display("FAIL illegal_set got=%b exp=1", illegal_op); end
    read_reg(4'd7, 32'd123, "illegal_r7_kept");
    checks++;
    if (illegal_op !== 1'b1) begin failures++; $display("FAIL illegal_sticky got=%b exp=1", illegal_op); end
`else
    read_reg(4'd7, 32'h0, "unknown_op_r7");
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.ext_we      = 1'b0;
    bus.ext_addr    = '0;
    bus.ext_wdata   = '0;
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    test_reset();
    test_add();
    test_sub_wrap();
    test_logic();
    test_back_to_back();
    test_r0_and_collide();
    test_reset_mid_exec();
    test_illegal_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
